// File: rtl/riscv_dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding, the
// full-word byte-select constant and the SRAM word-address width helper.
package riscv_dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRdWait  = 2'd1,
        StRmwWait = 2'd2,
        StResp    = 2'd3
    } dmem_state_e;

    localparam logic [3:0] BYTE_SEL_FULL = 4'hF;

    // Word address drops the two byte-offset bits of the decoded byte address.
    function automatic int unsigned sram_addr_width(input int unsigned dmem_addr_bit);
        return dmem_addr_bit - 2;
    endfunction

endpackage

// File: rtl/riscv_dmem_byte_merge.sv
// Byte-lane merge: each lane takes the new word where byte_sel is set,
// otherwise keeps the old word. Purely combinational.
module riscv_dmem_byte_merge #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] new_word,
    input  logic [3:0]      byte_sel,
    output logic [XLEN-1:0] merged_word
);

    // Select per byte lane between stored and incoming data.
    always_comb begin
        merged_word = old_word;
        for (int k = 0; k < 4; k++) begin
            if (byte_sel[k]) begin
                merged_word[k*8 +: 8] = new_word[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory responder: services CPU loads/stores against a single-port
// synchronous SRAM without byte enables; sub-word stores use read-modify-write.
module riscv_dmem_ctrl
    import riscv_dmem_ctrl_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned DMEM_ADDR_BIT = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_dmem_req,
    input  logic [XLEN-1:0]          i_dmem_addr,
    input  logic                     i_dmem_wr_en,
    input  logic [3:0]               i_dmem_byte_sel,
    input  logic [XLEN-1:0]          i_dmem_wr_data,
    output logic [XLEN-1:0]          o_dmem_rd_data,
    output logic                     o_dmem_ready,
    output logic                     o_sram_cs,
    output logic                     o_sram_we,
    output logic [DMEM_ADDR_BIT-3:0] o_sram_addr,
    output logic [XLEN-1:0]          o_sram_wdata,
    input  logic [XLEN-1:0]          i_sram_rdata
);

    localparam int unsigned SramAw = sram_addr_width(DMEM_ADDR_BIT);

    dmem_state_e       state_q, state_d;
    logic [SramAw-1:0] addr_q;
    logic [3:0]        byte_sel_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rd_data_q;

    logic              latch_en;
    logic              cs, we;
    logic [SramAw-1:0] sram_addr;
    logic [XLEN-1:0]   sram_wdata;
    logic [XLEN-1:0]   merged_word;
    logic [SramAw-1:0] req_word;

    // Byte offset and out-of-range upper bits are intentionally dropped (address wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_dmem_addr[XLEN-1:DMEM_ADDR_BIT], i_dmem_addr[1:0]};
    assign req_word         = i_dmem_addr[DMEM_ADDR_BIT-1:2];

    riscv_dmem_byte_merge #(
        .XLEN (XLEN)
    ) u_byte_merge (
        .old_word    (i_sram_rdata),
        .new_word    (wdata_q),
        .byte_sel    (byte_sel_q),
        .merged_word (merged_word)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the request at accept so later input changes are ignored.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q     <= '0;
            byte_sel_q <= '0;
            wdata_q    <= '0;
        end else if (latch_en) begin
            addr_q     <= req_word;
            byte_sel_q <= i_dmem_byte_sel;
            wdata_q    <= i_dmem_wr_data;
        end
    end

    // Capture load data the cycle after the SRAM read; held otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data_q <= '0;
        end else if (state_q == StRdWait) begin
            rd_data_q <= i_sram_rdata;
        end
    end

    // Next-state and SRAM control decode.
    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        cs         = 1'b0;
        we         = 1'b0;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (i_dmem_req) begin
                    // First access is issued straight from the request in the accept cycle.
                    latch_en   = 1'b1;
                    sram_addr  = req_word;
                    sram_wdata = i_dmem_wr_data;
                    if (!i_dmem_wr_en) begin
                        cs      = 1'b1;
                        state_d = StRdWait;
                    end else if (i_dmem_byte_sel == BYTE_SEL_FULL) begin
                        cs      = 1'b1;
                        we      = 1'b1;
                        state_d = StResp;
                    end else if (i_dmem_byte_sel == 4'h0) begin
                        state_d = StResp;
                    end else begin
                        cs      = 1'b1;
                        state_d = StRmwWait;
                    end
                end
            end
            StRdWait: begin
                state_d = StResp;
            end
            StRmwWait: begin
                cs         = 1'b1;
                we         = 1'b1;
                sram_wdata = merged_word;
                state_d    = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset gates the strobes so an in-flight RMW write is aborted immediately.
    assign o_sram_cs      = cs & ~i_rst;
    assign o_sram_we      = we & ~i_rst;
    assign o_sram_addr    = sram_addr;
    assign o_sram_wdata   = sram_wdata;
    assign o_dmem_ready   = (state_q == StResp);
    assign o_dmem_rd_data = rd_data_q;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed bench for riscv_dmem_ctrl with a behavioural synchronous SRAM.
module tb_riscv_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        wr_en;
    logic [3:0]  byte_sel;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic        sram_cs;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] mem [0:1023];
    bit          init_done = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cs_cnt   = 0;
    int we_cnt   = 0;

    // First two cycles of each transaction, captured at the falling edge.
    logic        c0_cs, c0_we, c1_cs, c1_we;
    logic [9:0]  c0_addr, c1_addr;
    logic [31:0] c0_wdata, c1_wdata;

    riscv_dmem_ctrl #(
        .XLEN          (32),
        .DMEM_ADDR_BIT (12)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_dmem_req      (req),
        .i_dmem_addr     (addr),
        .i_dmem_wr_en    (wr_en),
        .i_dmem_byte_sel (byte_sel),
        .i_dmem_wr_data  (wr_data),
        .o_dmem_rd_data  (rd_data),
        .o_dmem_ready    (ready),
        .o_sram_cs       (sram_cs),
        .o_sram_we       (sram_we),
        .o_sram_addr     (sram_addr),
        .o_sram_wdata    (sram_wdata),
        .i_sram_rdata    (sram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model; preloads known words on the first edge.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[5]     <= 32'h11223344;
            mem[7]     <= 32'h11223344;
            sram_rdata <= 32'h0;
            init_done  <= 1'b1;
        end else if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    // Access counters sampled mid-cycle.
    always @(negedge clk) begin
        if (sram_cs)            cs_cnt <= cs_cnt + 1;
        if (sram_cs && sram_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits for ready (bounded), checking latency and SRAM access count.
    task automatic wait_ready(input string tag, input int exp_lat, input int exp_cs);
        int k    = 0;
        bit got  = 1'b0;
        int base = cs_cnt;
        while (k < 10 && !got) begin
            @(negedge clk);
            if (k == 0) begin
                c0_cs = sram_cs; c0_we = sram_we; c0_addr = sram_addr; c0_wdata = sram_wdata;
            end
            if (k == 1) begin
                c1_cs = sram_cs; c1_we = sram_we; c1_addr = sram_addr; c1_wdata = sram_wdata;
            end
            if (ready) got = 1'b1;
            else       k++;
        end
        check({tag, "_latency"}, got ? k : 99, exp_lat);
        @(posedge clk);
        #1;
        check({tag, "_cs_count"}, cs_cnt - base, exp_cs);
    endtask

    task automatic set_req(input logic we_i, input logic [31:0] a, input logic [3:0] bs,
                           input logic [31:0] d);
        req      = 1'b1;
        wr_en    = we_i;
        addr     = a;
        byte_sel = bs;
        wr_data  = d;
    endtask

    initial begin
        int we_base;
        rst = 1'b1;
        set_req(1'b1, 32'h010, 4'hF, 32'hDEADBEEF);

        // Reset with a request held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", sram_cs, 0);
        check("rst_ready", ready, 0);
        check("rst_rd_data", rd_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full store issued the cycle after reset release.
        wait_ready("full_store", 1, 1);
        req = 1'b0;
        check("full_store_c0_cs", c0_cs, 1);
        check("full_store_c0_we", c0_we, 1);
        check("full_store_addr", c0_addr, 10'h004);
        check("full_store_mem", mem[4], 32'hDEADBEEF);

        // Load back.
        set_req(1'b0, 32'h010, 4'h0, 32'h0);
        wait_ready("load", 2, 1);
        req = 1'b0;
        check("load_addr", c0_addr, 10'h004);
        check("load_c0_we", c0_we, 0);
        check("load_rd_data", rd_data, 32'hDEADBEEF);

        // Partial store into 0x11223344.
        set_req(1'b1, 32'h014, 4'b0010, 32'h0000AA00);
        wait_ready("rmw", 2, 2);
        req = 1'b0;
        check("rmw_c0_we", c0_we, 0);
        check("rmw_c1_cs", c1_cs, 1);
        check("rmw_c1_we", c1_we, 1);
        check("rmw_c1_addr", c1_addr, 10'h005);
        check("rmw_c1_wdata", c1_wdata, 32'h1122AA44);
        check("rmw_mem", mem[5], 32'h1122AA44);

        // Address wrap: 0x1013 maps to word 4.
        set_req(1'b0, 32'h1013, 4'h0, 32'h0);
        wait_ready("wrap", 2, 1);
        req = 1'b0;
        check("wrap_addr", c0_addr, 10'h004);
        check("wrap_rd_data", rd_data, 32'hDEADBEEF);

        // Null store: no access, memory untouched.
        set_req(1'b1, 32'h010, 4'h0, 32'h55555555);
        wait_ready("null_store", 1, 0);
        req = 1'b0;
        check("null_store_mem", mem[4], 32'hDEADBEEF);
        check("null_store_rd_data", rd_data, 32'hDEADBEEF);

        // Back-to-back with request held through each completion.
        set_req(1'b0, 32'h014, 4'h0, 32'h0);
        wait_ready("b2b_load1", 2, 1);
        check("b2b_load1_data", rd_data, 32'h1122AA44);
        set_req(1'b1, 32'h018, 4'hF, 32'h0BADF00D);
        wait_ready("b2b_store", 1, 1);
        check("b2b_store_rd_hold", rd_data, 32'h1122AA44);
        check("b2b_store_mem", mem[6], 32'h0BADF00D);
        set_req(1'b0, 32'h018, 4'h0, 32'h0);
        wait_ready("b2b_load2", 2, 1);
        req = 1'b0;
        check("b2b_load2_data", rd_data, 32'h0BADF00D);
        @(negedge clk);
        check("idle_no_cs", sram_cs, 0);
        check("idle_no_ready", ready, 0);

        // Reset during RMW_WAIT aborts the write.
        @(posedge clk);
        #1;
        we_base = we_cnt;
        set_req(1'b1, 32'h01C, 4'b0001, 32'h000000FF);
        @(negedge clk);
        check("abort_c0_cs", sram_cs, 1);
        check("abort_c0_we", sram_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        check("abort_cs", sram_cs, 0);
        check("abort_we", sram_we, 0);
        check("abort_ready", ready, 0);
        check("abort_rd_data", rd_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_post_ready", ready, 0);
        check("abort_no_write", we_cnt - we_base, 0);
        check("abort_mem", mem[7], 32'h11223344);
        @(posedge clk);
        #1;
        set_req(1'b0, 32'h01C, 4'h0, 32'h0);
        wait_ready("abort_reload", 2, 1);
        req = 1'b0;
        check("abort_reload_data", rd_data, 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
